// File: rtl/ser_pkg.sv
// Shared types and constants for the framed serial deserializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int DEF_DATA_W = 8;

  // Even parity bit for a data word of arbitrary width.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop frees the head slot this cycle, so a push into a full FIFO is legal alongside it.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Framed LSB-first serial receiver: start, data, optional even parity, stop.
// Good bytes go to a small output FIFO; errors are registered 1-cycle pulses.
module serial_to_parallel
  import ser_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_valid,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overflow,
  output logic              busy,
  output logic [15:0]       rx_count
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bad;
  logic              r_frame_err;
  logic              r_parity_err;
  logic              r_overflow;
  logic [15:0]       r_rx_count;

  logic w_last_bit;
  logic w_stop_eval;
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_frame_err_d;
  logic w_parity_err_d;
  logic w_overflow_d;

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Only serial_valid cycles advance; a 0 stop bit still returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_stop_eval = 1'b0;
    case (r_state)
      IDLE:   if (serial_valid && serial_in == START_BIT) w_state_nxt = DATA;
      DATA:   if (serial_valid && w_last_bit) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (serial_valid) w_state_nxt = STOP;
      STOP: begin
        if (serial_valid) begin
          w_state_nxt = IDLE;
          w_stop_eval = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_frame_err_d  = w_stop_eval && (serial_in != STOP_BIT);
  assign w_parity_err_d = w_stop_eval && (serial_in == STOP_BIT) && r_par_bad;
  assign w_push_req     = w_stop_eval && (serial_in == STOP_BIT) && !r_par_bad;

  assign w_pop        = out_ready && !w_empty;
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_overflow_d = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else if (serial_valid) begin
      case (r_state)
        IDLE: begin
          if (serial_in == START_BIT) begin
            r_cnt     <= '0;
            r_par_bad <= 1'b0;
          end
        end
        DATA: begin
          r_shift[r_cnt] <= serial_in;
          r_cnt          <= r_cnt + 1'b1;
        end
        PARITY:  r_par_bad <= (serial_in != even_par(64'(r_shift)));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
      r_rx_count   <= '0;
    end else begin
      r_frame_err  <= w_frame_err_d;
      r_parity_err <= w_parity_err_d;
      r_overflow   <= w_overflow_d;
      if (w_push) r_rx_count <= r_rx_count + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (r_shift),
    .rdata (out_data),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid  = !w_empty;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE);
  assign rx_count   = r_rx_count;

endmodule
